alu_arbiter: RTL

//  Shares the single registered 32-bit ALU between two requesters (e.g. EX

---
 rtl/alu_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one registered ALU between two requesters. An op is granted
//   round-robin, its operands are registered onto the ALU port, the arbiter
//   waits out the ALU latency, captures the result and flags, and returns
//   them to the granted requester as a one-cycle response pulse.
//   Only one op is in flight at a time.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   req{0,1}_valid/_op/_a/_b   requester op (op: 000 ADD 001 SUB 010 XOR 011 BEQ 100 OR)
//   req{0,1}_ready             combinational accept, only in IDLE, only for the grantee
//   rsp{0,1}_valid             one-cycle response pulse for that requester
//   rsp_result/zero/ovf/branch shared response bus, held until the next capture
//   busy                       an op is in flight
//   alu_a/alu_b/alu_ctrl       registered ALU operands and op code
//   alu_r/alu_ovf/alu_branch   ALU result and flags
module alu_arbiter #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_ovf,
    output logic             rsp_branch,
    output logic             busy,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_ovf,
    input  logic             alu_branch
);

    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_BEQ = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;

    localparam int              CNT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ALU_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             grant_id_q;
    logic             last_grant_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [2:0]       alu_ctrl_q;
    logic             rsp0_valid_q;
    logic             rsp1_valid_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_zero_q;
    logic             rsp_ovf_q;
    logic             rsp_branch_q;
    logic             gnt0_d;
    logic             gnt1_d;

    // Shapes the raw ALU outputs into the response. BEQ never forwards R
    // (the ALU may leave a stale value there on a taken branch); zero is
    // derived from the shaped result rather than trusted from the ALU.
    function automatic logic [WIDTH+2:0] shape_rsp(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] r,
        input logic             ovf,
        input logic             br
    );
        logic [WIDTH-1:0] res;
        logic             o;
        logic             b;
        res = r;
        o   = ovf;
        b   = 1'b0;
        case (op)
            OP_BEQ: begin
                res = '0;
                o   = 1'b0;
                b   = br;
            end
            OP_XOR, OP_OR: o = 1'b0;
            default: ;
        endcase
        return {res, (res == '0), o, b};
    endfunction

    // Round-robin grant: a lone requester always wins; on contention the
    // requester that did not win last time goes first.
    always_comb begin
        gnt0_d = 1'b0;
        gnt1_d = 1'b0;
        if (state_q == IDLE) begin
            if (req0_valid && req1_valid) begin
                gnt0_d = last_grant_q;
                gnt1_d = !last_grant_q;
            end else begin
                gnt0_d = req0_valid;
                gnt1_d = req1_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            grant_id_q   <= 1'b0;
            last_grant_q <= 1'b1;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= 3'b000;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            rsp_branch_q <= 1'b0;
        end else begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt0_d || gnt1_d) begin
                        alu_ctrl_q   <= gnt1_d ? req1_op : req0_op;
                        alu_a_q      <= gnt1_d ? req1_a  : req0_a;
                        alu_b_q      <= gnt1_d ? req1_b  : req0_b;
                        grant_id_q   <= gnt1_d;
                        last_grant_q <= gnt1_d;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= CNT_INIT;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        {rsp_result_q, rsp_zero_q, rsp_ovf_q, rsp_branch_q}
                            <= shape_rsp(alu_ctrl_q, alu_r, alu_ovf, alu_branch);
                        rsp0_valid_q <= !grant_id_q;
                        rsp1_valid_q <= grant_id_q;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req0_ready = gnt0_d;
    assign req1_ready = gnt1_d;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_ovf    = rsp_ovf_q;
    assign rsp_branch = rsp_branch_q;
    assign busy       = (state_q != IDLE);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_ctrl   = alu_ctrl_q;

endmodule
